// File: rtl/shake256_squeeze_pkg.sv
// ============================================================================
// Module : shake256_squeeze_pkg
// Brief  : Shared constants and FSM encoding for the SHAKE squeeze blocks.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shake256_squeeze_pkg;

    localparam int SHAKE256_RATE = 136;
    localparam int SHAKE128_RATE = 168;
    localparam int STATE_W       = 1600;
    localparam int STATE_BYTES   = STATE_W / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EMIT     = 2'd1,
        PERM_REQ = 2'd2,
        DONE     = 2'd3
    } sq_state_e;

endpackage

`default_nettype wire

// File: rtl/shake256_squeeze_state_byte_sel.sv
// ============================================================================
// Module : shake256_squeeze_state_byte_sel
// Brief  : Selects byte pos_i of a 1600-bit Keccak state (0 when out of range).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shake256_squeeze_state_byte_sel
    import shake256_squeeze_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic [31:0]        pos_i,
    output logic [7:0]         byte_o
);

    logic [10:0] w_bit_idx;

    assign w_bit_idx = {pos_i[7:0], 3'b000};

    always_comb begin
        byte_o = 8'h00;
        if (pos_i < 32'(STATE_BYTES)) begin
            byte_o = state_i[w_bit_idx +: 8];
        end
    end

endmodule

`default_nettype wire

// File: rtl/shake256_squeeze.sv
// ============================================================================
// Module : shake256_squeeze
// Brief  : SHAKE256 squeeze stage; streams output bytes, requesting external
//          Keccak-f permutations at rate boundaries. Optional abort input is
//          enabled with SHAKE256_SQUEEZE_ABORT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shake256_squeeze
    import shake256_squeeze_pkg::*;
#(
    parameter int RATE  = SHAKE256_RATE,
    parameter int LEN_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rtr,
    input  logic [STATE_W-1:0] linear_state_s_in,
    input  logic [31:0]        state_pos_in,
    input  logic [LEN_W-1:0]   outlen,
    output logic [7:0]         out_byte,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               perm_req,
    output logic [STATE_W-1:0] perm_state_out,
    input  logic               perm_ack,
    input  logic [STATE_W-1:0] perm_state_in,
    output logic [STATE_W-1:0] linear_state_s_out,
    output logic [31:0]        state_pos_out,
    output logic               rts,
    output logic               busy
`ifdef SHAKE256_SQUEEZE_ABORT_EN
    ,
    input  logic               abort
`endif
);

    localparam logic [31:0] c_RATE32 = 32'(RATE);

    sq_state_e          fsm_q, fsm_d;
    logic [STATE_W-1:0] st_q, st_d;
    logic [31:0]        pos_q, pos_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               abort_pend_q, abort_pend_d;
    logic               w_abort;
    logic [31:0]        w_pos_inc;

`ifdef SHAKE256_SQUEEZE_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_pos_inc = pos_q + 32'd1;

    shake256_squeeze_state_byte_sel u_byte_sel (
        .state_i (st_q),
        .pos_i   (pos_q),
        .byte_o  (out_byte)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q        <= IDLE;
            st_q         <= '0;
            pos_q        <= '0;
            rem_q        <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            st_q         <= st_d;
            pos_q        <= pos_d;
            rem_q        <= rem_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    always_comb begin
        fsm_d        = fsm_q;
        st_d         = st_q;
        pos_d        = pos_q;
        rem_d        = rem_q;
        abort_pend_d = abort_pend_q;
        out_valid    = 1'b0;
        perm_req     = 1'b0;
        rts          = 1'b0;

        case (fsm_q)
            IDLE: begin
                abort_pend_d = 1'b0;
                if (rtr) begin
                    st_d  = linear_state_s_in;
                    pos_d = state_pos_in;
                    rem_d = outlen;
                    if (outlen == '0) begin
                        fsm_d = DONE;
                    end else if (state_pos_in >= c_RATE32) begin
                        fsm_d = PERM_REQ;
                    end else begin
                        fsm_d = EMIT;
                    end
                end
            end

            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    pos_d = w_pos_inc;
                    if (rem_q != '0) begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                    // A final byte landing on the boundary skips the permutation;
                    // the next call sees pos=RATE and permutes first.
                    if (rem_q <= LEN_W'(1)) begin
                        fsm_d = DONE;
                    end else if (w_pos_inc == c_RATE32) begin
                        fsm_d = PERM_REQ;
                    end
                end
                if (w_abort) begin
                    fsm_d = IDLE;
                end
            end

            PERM_REQ: begin
                perm_req = 1'b1;
                if (w_abort) begin
                    abort_pend_d = 1'b1;
                end
                if (perm_ack) begin
                    st_d         = perm_state_in;
                    pos_d        = '0;
                    fsm_d        = (abort_pend_q || w_abort) ? IDLE : EMIT;
                    abort_pend_d = 1'b0;
                end
            end

            DONE: begin
                rts   = ~w_abort;
                fsm_d = IDLE;
            end

            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    assign perm_state_out     = st_q;
    assign linear_state_s_out = st_q;
    assign state_pos_out      = pos_q;
    assign busy               = (fsm_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_shake256_squeeze.sv
// ============================================================================
// Module : tb_shake256_squeeze
// Brief  : Directed, table-driven self-checking bench for shake256_squeeze.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shake256_squeeze;
    import shake256_squeeze_pkg::*;

    localparam int RATE  = 136;
    localparam int LEN_W = 16;

    logic               clock = 1'b0;
    logic               reset;
    logic               rtr;
    logic [STATE_W-1:0] linear_state_s_in;
    logic [31:0]        state_pos_in;
    logic [LEN_W-1:0]   outlen;
    logic [7:0]         out_byte;
    logic               out_valid;
    logic               out_ready;
    logic               perm_req;
    logic [STATE_W-1:0] perm_state_out;
    logic               perm_ack;
    logic [STATE_W-1:0] perm_state_in;
    logic [STATE_W-1:0] linear_state_s_out;
    logic [31:0]        state_pos_out;
    logic               rts;
    logic               busy;
`ifdef SHAKE256_SQUEEZE_ABORT_EN
    logic               abort;
`endif

    shake256_squeeze #(.RATE(RATE), .LEN_W(LEN_W)) dut (
        .clock              (clock),
        .reset              (reset),
        .rtr                (rtr),
        .linear_state_s_in  (linear_state_s_in),
        .state_pos_in       (state_pos_in),
        .outlen             (outlen),
        .out_byte           (out_byte),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .perm_req           (perm_req),
        .perm_state_out     (perm_state_out),
        .perm_ack           (perm_ack),
        .perm_state_in      (perm_state_in),
        .linear_state_s_out (linear_state_s_out),
        .state_pos_out      (state_pos_out),
        .rts                (rts),
        .busy               (busy)
`ifdef SHAKE256_SQUEEZE_ABORT_EN
        ,
        .abort              (abort)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int pos_in;
        int len;
        bit rnd;
        int ack_dly;
        int exp_bytes;
        int exp_perms;
        int exp_pos;
        int exp_first;
        int exp_rts;
    } vec_t;

    int         n_cmp = 0;
    int         n_err = 0;
    int         g_perm = 0;
    logic [7:0] got_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [STATE_W-1:0] init_state();
        logic [STATE_W-1:0] s;
        for (int i = 0; i < STATE_BYTES; i++) s[8*i +: 8] = 8'((i + 1) * 17);
        return s;
    endfunction

    function automatic logic [STATE_W-1:0] perm_pattern(input int k);
        logic [STATE_W-1:0] s;
        for (int i = 0; i < STATE_BYTES; i++) s[8*i +: 8] = 8'(i * 13 + k * 57 + 1);
        return s;
    endfunction

    // Reference model: mst/mpos track the sponge state the DUT should hold.
    task automatic run_op(input vec_t v, output int nb, output int np, output int first,
                          output int rts_at, output logic [STATE_W-1:0] mst, output int mpos);
        logic [7:0] prev_byte = 8'h00;
        bit         prev_stall = 1'b0;
        bit         prev_req = 1'b0;
        bit         done = 1'b0;
        int         wait_c = 0;
        nb = 0; np = 0; first = -1; rts_at = -1;
        mst  = init_state();
        mpos = v.pos_in;
        @(negedge clock);
        linear_state_s_in = mst;
        state_pos_in      = 32'(v.pos_in);
        outlen            = LEN_W'(v.len);
        rtr               = 1'b1;
        for (int cyc = 1; cyc <= 4000 && !done; cyc++) begin
            @(negedge clock);
            rtr       = 1'b0;
            perm_ack  = 1'b0;
            out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if ((out_valid || perm_req) && first < 0) first = cyc;
            if (out_valid) begin
                if (prev_stall) chk("stall_hold", out_byte, prev_byte);
                chk("byte", out_byte, mst[8*mpos +: 8]);
                if (out_ready) begin
                    got_q.push_back(out_byte);
                    nb++;
                    mpos++;
                end
                prev_stall = !out_ready;
                prev_byte  = out_byte;
            end else begin
                prev_stall = 1'b0;
            end
            if (perm_req) begin
                if (!prev_req) begin
                    np++;
                    wait_c = 0;
                    chk("perm_state_out", perm_state_out === mst, 1);
                end
                if (wait_c == v.ack_dly) begin
                    g_perm++;
                    mst           = perm_pattern(g_perm);
                    perm_state_in = mst;
                    perm_ack      = 1'b1;
                    mpos          = 0;
                end
                wait_c++;
            end
            prev_req = perm_req && !perm_ack;
            if (rts) begin
                rts_at = cyc;
                done   = 1'b1;
            end
        end
    endtask

    task automatic reset_mid(input int pos_in, input int cycles, input string nm);
        @(negedge clock);
        linear_state_s_in = init_state();
        state_pos_in      = 32'(pos_in);
        outlen            = LEN_W'(10);
        out_ready         = 1'b1;
        rtr               = 1'b1;
        repeat (cycles) begin
            @(negedge clock);
            rtr = 1'b0;
        end
        chk({nm, "_active"}, (pos_in < RATE) ? out_valid : perm_req, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk({nm, "_valid"}, out_valid, 0);
        chk({nm, "_req"}, perm_req, 0);
        chk({nm, "_rts"}, rts, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_pos"}, state_pos_out, 0);
        chk({nm, "_state"}, linear_state_s_out === '0, 1);
    endtask

    initial begin
        vec_t               vecs[6];
        int                 nb, np, first, rts_at, mpos;
        logic [STATE_W-1:0] mst;

        vecs[0] = '{0,   4,   1'b0, 0,  4,   0, 4,   1,  5};
        vecs[1] = '{136, 2,   1'b0, 24, 2,   1, 2,   1,  28};
        vecs[2] = '{134, 5,   1'b0, 3,  5,   1, 3,   1,  10};
        vecs[3] = '{50,  0,   1'b0, 0,  0,   0, 50,  -1, 1};
        vecs[4] = '{135, 1,   1'b0, 0,  1,   0, 136, 1,  2};
        vecs[5] = '{0,   300, 1'b1, 2,  300, 2, 28,  1,  -1};

        reset = 1'b1; rtr = 1'b0; out_ready = 1'b1; perm_ack = 1'b0;
        linear_state_s_in = '0; state_pos_in = '0; outlen = '0; perm_state_in = '0;
`ifdef SHAKE256_SQUEEZE_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_req", perm_req, 0);
        chk("rst_rts", rts, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pos", state_pos_out, 0);
        chk("rst_state", linear_state_s_out === '0, 1);

        reset_mid(0, 3, "rst_emit");
        reset_mid(136, 3, "rst_perm");

`ifdef SHAKE256_SQUEEZE_ABORT_EN
        @(negedge clock);
        linear_state_s_in = init_state(); state_pos_in = 32'd136; outlen = LEN_W'(4); rtr = 1'b1;
        @(negedge clock);
        rtr = 1'b0;
        chk("abort_req", perm_req, 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        @(negedge clock);
        perm_state_in = perm_pattern(99);
        perm_ack      = 1'b1;
        @(negedge clock);
        perm_ack = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_rts", rts, 0);
        chk("abort_pos", state_pos_out, 0);
        chk("abort_state", linear_state_s_out === perm_pattern(99), 1);
`endif

        for (int t = 0; t < 6; t++) begin
            got_q.delete();
            run_op(vecs[t], nb, np, first, rts_at, mst, mpos);
            chk("rts_seen", rts_at > 0, 1);
            chk("n_bytes", nb, vecs[t].exp_bytes);
            chk("n_perms", np, vecs[t].exp_perms);
            chk("first_lat", first, vecs[t].exp_first);
            if (vecs[t].exp_rts >= 0) chk("rts_lat", rts_at, vecs[t].exp_rts);
            chk("pos_out", state_pos_out, vecs[t].exp_pos);
            chk("pos_model", state_pos_out, mpos);
            chk("state_out", linear_state_s_out === mst, 1);
            if (t == 0) begin
                chk("s1_b0", got_q.size() > 0 ? got_q[0] : 8'h00, 8'h11);
                chk("s1_b1", got_q.size() > 1 ? got_q[1] : 8'h00, 8'h22);
                chk("s1_b2", got_q.size() > 2 ? got_q[2] : 8'h00, 8'h33);
                chk("s1_b3", got_q.size() > 3 ? got_q[3] : 8'h00, 8'h44);
            end
            @(negedge clock);
            out_ready = 1'b1;
            chk("idle_busy", busy, 0);
            chk("idle_rts", rts, 0);
            chk("idle_pos", state_pos_out, vecs[t].exp_pos);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
